st_bus_tx: RTL and testbench
============================

ST_BUS_TX -- requirements
Module: st_bus_tx

Interface
REQ-001 Parameter NUM_CH, default 32, number of 8-bit channels per frame.
REQ-002 Parameter BITS_PER_CH, default 8, bits per channel, MSB first.
REQ-003 clk50  in  1  system clock, 50 MHz; the only clock.
REQ-004 reset_tx_rg  in  1  reset, synchronous, active-low.
REQ-005 f0  in  1  frame sync, active-low, async to clk50.
REQ-006 c4  in  1  bit clock, 2 periods per bit, async to clk50.
REQ-007 wr_en  in  1  write strobe, one clk50 cycle per write.
REQ-008 wr_ch  in  5  channel index for write.
REQ-009 wr_data  in  8  channel byte for write.
REQ-010 commit  in  1  one-cycle pulse; requests back-to-front bank swap.
REQ-011 data_to_dt  out  1  serial TDM output.
REQ-012 frame_start  out  1  one-cycle pulse at each frame start.
REQ-013 locked  out  1  high once an f0 frame start has been seen.
REQ-014 slip_err  out  1  sticky; f0 seen at unexpected position.

Function
REQ-015 f0 and c4 SHALL each pass a 2-FF synchronizer; c4 rising edge detected as a 1-cycle strobe c4_rise on synchronized signal.
REQ-016 Frame position SHALL be a 10-bit counter cnt, advanced only on c4_rise; range 0..2*NUM_CH*BITS_PER_CH-1 (0..511 default), wrapping to 0 after max.
REQ-017 On c4_rise with synchronized f0 low: cnt <= 0, frame_start pulses, locked <= 1.
REQ-018 If f0-low c4_rise occurs while locked and cnt != max, slip_err SHALL set; cnt still resets to 0.
REQ-019 f0 low on consecutive c4_rise: only the first is a frame start; subsequent ones while f0 stays low are ignored.
REQ-020 Bit index = cnt[9:1]; channel = bit index / 8; bit = 7 - (bit index mod 8).
REQ-021 data_to_dt SHALL update one clk50 cycle after c4_rise when new cnt is even, with the front-bank bit for the new position; held otherwise.
REQ-022 While locked = 0, data_to_dt SHALL be 1 (idle) and cnt held at 0.
REQ-023 Channel store: two banks, NUM_CH x 8 each; wr_en writes wr_data into back bank at wr_ch; wr_ch >= NUM_CH ignored.
REQ-024 commit SHALL set a pending flag; at next frame start, front/back banks swap and pending clears; pending with no frame start remains pending.
REQ-025 Swap SHALL take effect for channel 0 bit 7 of the same frame.
REQ-026 After swap, back bank SHALL be a copy of new front (copy-on-swap, one entry per clk50 cycle, done well inside one bit period); wr_en during copy wins over copy for its entry.
REQ-027 wr_en and frame start in the same cycle: write goes to pre-swap back bank.
REQ-028 Latency raw c4 edge to data_to_dt change: 3-4 clk50 cycles.

Reset
REQ-029 reset_tx_rg low at clk50 edge: cnt=0, locked=0, slip_err=0, frame_start=0, pending=0, data_to_dt=1, bank select=0.
REQ-030 Both banks SHALL reset to 8'hFF (idle pattern).
REQ-031 Reset mid-frame SHALL abort output immediately; re-lock requires new f0.

Structure
REQ-032 Shared package st_bus_pkg SHALL hold NUM_CH default, BITS_PER_CH, frame length constant, idle byte 8'hFF, counter width.
REQ-033 Synchronizer plus edge detect SHALL be sub-module st_bus_sync (one instance each for f0, c4).

Verification
REQ-034 Reset, no f0, 600 c4 periods -> data_to_dt=1, locked=0 throughout.
REQ-035 Write ch0=8'hA5, ch1=8'h3C, commit, f0 low one c4 period -> frame_start once, data_to_dt emits 1010010100111100 at 2 c4 periods per bit, then 1s.
REQ-036 Free-running 512-c4 frames with f0 every frame -> slip_err stays 0, pattern repeats identically.
REQ-037 f0 asserted at cnt=300 -> slip_err=1, output restarts at ch0 bit 7.
REQ-038 Write ch5=8'h00 without commit across two frames -> ch5 stays 8'hFF; commit -> 8'h00 from next frame.
REQ-039 reset_tx_rg low at cnt=100 -> data_to_dt=1 next cycle, locked=0, banks 8'hFF.

Source files
------------

// File: rtl/st_bus_pkg.sv
// Shared constants for the ST-bus TDM transmitter: frame geometry, counter
// width and the idle byte that fills the channel banks out of reset.
package st_bus_pkg;

  localparam int         NUM_CH_DEF      = 32;
  localparam int         BITS_PER_CH_DEF = 8;
  localparam int         FRAME_LEN       = 2 * NUM_CH_DEF * BITS_PER_CH_DEF;
  localparam int         CNT_W           = 10;
  localparam int         CH_W            = 5;
  localparam logic [7:0] IDLE_BYTE       = 8'hFF;

endpackage

// File: rtl/st_bus_sync.sv
// Two-flop synchronizer for an asynchronous level, plus a one-cycle strobe
// on the rising edge of the synchronized value.
module st_bus_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk50_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic [1:0] meta_q;
  logic       prev_q;

  always_ff @(posedge clk50_i) begin
    if (!rst_ni) begin
      meta_q <= {2{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      meta_q <= {meta_q[0], async_i};
      prev_q <= meta_q[1];
    end
  end

  assign sync_o = meta_q[1];
  assign rise_o = meta_q[1] & ~prev_q;

endmodule

// File: rtl/st_bus_tx.sv
// ST-bus serial transmitter: double-buffered channel store clocked out MSB
// first, two c4 periods per bit, framed by f0.
module st_bus_tx
  import st_bus_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int BITS_PER_CH = BITS_PER_CH_DEF
) (
  input  logic            clk50,
  input  logic            reset_tx_rg,
  input  logic            f0,
  input  logic            c4,
  input  logic            wr_en,
  input  logic [CH_W-1:0] wr_ch,
  input  logic [7:0]      wr_data,
  input  logic            commit,
  output logic            data_to_dt,
  output logic            frame_start,
  output logic            locked,
  output logic            slip_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2 * NUM_CH * BITS_PER_CH - 1);
  localparam int               FLAT_W  = NUM_CH * 8;
  localparam int               FIDX_W  = $clog2(FLAT_W);

  logic f0_s, f0_rise_unused, c4_level_unused, c4_rise;

  st_bus_sync #(.RST_VAL(1'b1)) u_f0_sync (
    .clk50_i (clk50),
    .rst_ni  (reset_tx_rg),
    .async_i (f0),
    .sync_o  (f0_s),
    .rise_o  (f0_rise_unused)
  );

  st_bus_sync #(.RST_VAL(1'b0)) u_c4_sync (
    .clk50_i (clk50),
    .rst_ni  (reset_tx_rg),
    .async_i (c4),
    .sync_o  (c4_level_unused),
    .rise_o  (c4_rise)
  );

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              locked_q, slip_q, fs_q, pend_q, sel_q, f0_low_q, upd_q, dt_q;
  logic              copy_q;
  logic [CH_W-1:0]   copy_idx_q;
  logic [NUM_CH-1:0] wmask_q;
  logic [FLAT_W-1:0] front_flat;
  logic [FIDX_W-1:0] rd_idx;
  logic              fs_go, swap_go, wr_ok, tx_bit;

  // Only the first c4 rise of a low f0 stretch counts as a frame start.
  assign fs_go   = c4_rise & ~f0_s & ~f0_low_q;
  assign swap_go = fs_go & pend_q;
  assign wr_ok   = wr_en && (int'(wr_ch) < NUM_CH);

  always_comb begin
    cnt_d = cnt_q;
    if (fs_go) begin
      cnt_d = '0;
    end else if (c4_rise && locked_q) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
  end

  always_comb begin
    int bi;
    bi     = int'(cnt_q[CNT_W-1:1]);
    rd_idx = FIDX_W'((bi / BITS_PER_CH) * 8 + (BITS_PER_CH - 1 - (bi % BITS_PER_CH)));
    tx_bit = front_flat[rd_idx];
  end

  always_ff @(posedge clk50) begin
    if (!reset_tx_rg) begin
      cnt_q      <= '0;
      locked_q   <= 1'b0;
      slip_q     <= 1'b0;
      fs_q       <= 1'b0;
      pend_q     <= 1'b0;
      sel_q      <= 1'b0;
      f0_low_q   <= 1'b0;
      upd_q      <= 1'b0;
      dt_q       <= 1'b1;
      copy_q     <= 1'b0;
      copy_idx_q <= '0;
      wmask_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      fs_q  <= fs_go;
      upd_q <= c4_rise;
      if (c4_rise) f0_low_q <= ~f0_s;
      if (fs_go) begin
        locked_q <= 1'b1;
        if (locked_q && cnt_q != CNT_MAX) slip_q <= 1'b1;
      end
      if (swap_go) begin
        sel_q  <= ~sel_q;
        pend_q <= commit;
      end else if (commit) begin
        pend_q <= 1'b1;
      end
      // cnt_q already holds the new position one cycle after c4_rise.
      if (!locked_q) dt_q <= 1'b1;
      else if (upd_q && !cnt_q[0]) dt_q <= tx_bit;
      if (swap_go) begin
        copy_q     <= 1'b1;
        copy_idx_q <= '0;
        wmask_q    <= '0;
      end else begin
        if (copy_q) begin
          copy_idx_q <= copy_idx_q + 1'b1;
          if (copy_idx_q == CH_W'(NUM_CH - 1)) copy_q <= 1'b0;
        end
        if (wr_ok) wmask_q[wr_ch] <= 1'b1;
      end
    end
  end

  // Entries written since the swap are newer than the front copy, so the copy skips them.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [7:0] ent_q [2];
    logic       wr_hit, cp_hit;

    assign wr_hit = wr_en && (wr_ch == CH_W'(gi));
    assign cp_hit = copy_q && (copy_idx_q == CH_W'(gi)) && !wmask_q[gi];

    always_ff @(posedge clk50) begin
      if (!reset_tx_rg) begin
        ent_q[0] <= IDLE_BYTE;
        ent_q[1] <= IDLE_BYTE;
      end else if (wr_hit) begin
        ent_q[~sel_q] <= wr_data;
      end else if (cp_hit) begin
        ent_q[~sel_q] <= ent_q[sel_q];
      end
    end

    assign front_flat[gi*8 +: 8] = ent_q[sel_q];
  end

  assign data_to_dt  = dt_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign slip_err    = slip_q;

endmodule

// File: tb/tb_st_bus_tx.sv
// Randomized bench for st_bus_tx against a frame-level reference model
// (position counter, front/back byte arrays, pending-swap flag).
module tb_st_bus_tx;

  logic       clk50;
  logic       reset_tx_rg;
  logic       f0, c4, wr_en, commit;
  logic [4:0] wr_ch;
  logic [7:0] wr_data;
  logic       data_to_dt, frame_start, locked, slip_err;

  st_bus_tx dut (
    .clk50       (clk50),
    .reset_tx_rg (reset_tx_rg),
    .f0          (f0),
    .c4          (c4),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_data     (wr_data),
    .commit      (commit),
    .data_to_dt  (data_to_dt),
    .frame_start (frame_start),
    .locked      (locked),
    .slip_err    (slip_err)
  );

  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  int n_tests = 0;
  int n_fail  = 0;
  int fs_seen = 0;

  always @(posedge clk50) if (frame_start === 1'b1) fs_seen++;

  // Reference model state
  int         m_pos;
  bit         m_locked, m_slip, m_pend, m_f0_low;
  int         m_fs = 0;
  logic [7:0] m_front [32];
  logic [7:0] m_back  [32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_locked = 0; m_slip = 0; m_pend = 0; m_f0_low = 0;
    for (int i = 0; i < 32; i++) begin
      m_front[i] = 8'hFF;
      m_back[i]  = 8'hFF;
    end
  endtask

  function automatic logic exp_dt();
    int         bi;
    int         b;
    logic [7:0] by;
    if (!m_locked) return 1'b1;
    bi = m_pos / 2;
    by = m_front[5'(bi / 8)];
    b  = 7 - (bi % 8);
    return by[3'(b)];
  endfunction

  // One c4 period; f0l drives f0 low across this period's rising edge.
  task automatic tick(input bit f0l);
    f0 = f0l ? 1'b0 : 1'b1;
    @(negedge clk50);
    c4 = 1'b1;
    if (f0l && !m_f0_low) begin
      if (m_locked && m_pos != 511) m_slip = 1;
      m_pos = 0;
      m_locked = 1;
      m_fs++;
      if (m_pend) begin
        for (int i = 0; i < 32; i++) m_front[i] = m_back[i];
        m_pend = 0;
      end
    end else if (m_locked) begin
      m_pos = (m_pos + 1) % 512;
    end
    m_f0_low = f0l;
    repeat (4) @(negedge clk50);
    c4 = 1'b0;
    repeat (3) @(negedge clk50);
    check("dt", 32'(data_to_dt), 32'(exp_dt()));
    check("locked", 32'(locked), 32'(m_locked));
  endtask

  task automatic frame(input int n, input int f0_ticks);
    for (int i = 0; i < n; i++) tick(i < f0_ticks);
  endtask

  task automatic write(input int ch, input logic [7:0] data);
    @(negedge clk50);
    wr_en = 1'b1; wr_ch = 5'(ch); wr_data = data;
    @(negedge clk50);
    wr_en = 1'b0;
    m_back[ch] = data;
    $display("[TB] write ch=%0d data=%02h", ch, data);
  endtask

  task automatic do_commit();
    @(negedge clk50);
    commit = 1'b1;
    @(negedge clk50);
    commit = 1'b0;
    m_pend = 1;
    $display("[TB] commit");
  endtask

  task automatic frame_checks(input string tag);
    check({tag, "_fs_count"}, 32'(fs_seen), 32'(m_fs));
    check({tag, "_slip"}, 32'(slip_err), 32'(m_slip));
    $display("[TB] %s done, frames=%0d", tag, m_fs);
  endtask

  initial begin
    logic [15:0] pat;
    reset_tx_rg = 1'b0; f0 = 1'b1; c4 = 1'b0;
    wr_en = 1'b0; wr_ch = '0; wr_data = '0; commit = 1'b0;
    model_reset();
    repeat (3) @(negedge clk50);
    check("rst_dt", 32'(data_to_dt), 32'd1);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_slip", 32'(slip_err), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    reset_tx_rg = 1'b1;

    // No f0: idle output, never locks
    frame(600, 0);
    frame_checks("idle");

    // Directed pattern on ch0/ch1
    write(0, 8'hA5);
    write(1, 8'h3C);
    do_commit();
    pat = '0;
    for (int i = 0; i < 512; i++) begin
      tick(i == 0);
      if (i < 32 && (i % 2) == 0) pat = {pat[14:0], data_to_dt};
    end
    check("pattern", 32'(pat), 32'h0000A53C);
    frame_checks("directed");

    // Free-running aligned frames
    frame(512, 1);
    frame(512, 1);
    frame_checks("freerun");

    // Uncommitted write stays invisible until commit
    write(5, 8'h00);
    frame(512, 1);
    frame(512, 1);
    do_commit();
    frame(512, 1);
    frame_checks("commit");

    // Misaligned f0 at position 300
    write(6, 8'h00);
    do_commit();
    frame(301, 1);
    frame(512, 1);
    check("slip_set", 32'(slip_err), 32'd1);
    frame_checks("slip");

    // Reset mid-frame at position 100
    frame(101, 1);
    @(negedge clk50);
    reset_tx_rg = 1'b0;
    @(negedge clk50);
    check("midrst_dt", 32'(data_to_dt), 32'd1);
    check("midrst_locked", 32'(locked), 32'd0);
    check("midrst_slip", 32'(slip_err), 32'd0);
    reset_tx_rg = 1'b1;
    model_reset();
    frame(20, 0);
    frame(512, 1);
    frame_checks("midrst");

    // Random writes and commits; second frame holds f0 low for 3 c4 periods
    for (int fr = 0; fr < 2; fr++) begin
      for (int i = 0; i < 512; i++) begin
        tick(i < (fr == 1 ? 3 : 1));
        if ($urandom_range(0, 15) == 0) write(int'($urandom_range(0, 31)), 8'($urandom));
        if ($urandom_range(0, 99) == 0) do_commit();
      end
    end
    frame(512, 1);
    frame_checks("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
